instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program memory address width; depth is 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width; opcode is bits [15:10].
REQ-003 SHALL be clocked by one clock and reset by an asynchronous active-low reset; no other clock or reset.
REQ-004 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ir_en, input, 1, capture mem[pc] into the instruction register.
REQ-007 SHALL have port incr_en, input, 1, increment pc.
REQ-008 SHALL have port pc_load, input, 1, load pc from pc_load_val (jump).
REQ-009 SHALL have port pc_load_val, input, ADDR_W, jump target.
REQ-010 SHALL have port prog_mode, input, 1, level request for program-load mode.
REQ-011 SHALL have port prog_we, input, 1, program memory write strobe.
REQ-012 SHALL have port prog_addr, input, ADDR_W, program write address.
REQ-013 SHALL have port prog_data, input, DATA_W, program write data.
REQ-014 SHALL have port restart, input, 1, single-cycle pulse that leaves HALT.
REQ-015 SHALL have port instruction, output, DATA_W, instruction register contents.
REQ-016 SHALL have port pc, output, ADDR_W, current program counter.
REQ-017 SHALL have port halted, output, 1, high while in HALT.
REQ-018 SHALL have port loading, output, 1, high while in LOAD.

Function
REQ-019 SHALL implement three states, RUN, LOAD and HALT, held in a registered state variable.
REQ-020 In RUN, with ir_en=1, instruction SHALL equal mem[pc-before-edge] one clock after the edge; latency is one cycle.
REQ-021 In RUN, with ir_en and incr_en both 1 on the same edge, the capture SHALL use the pre-increment pc.
REQ-022 In RUN, pc_load=1 SHALL set pc to pc_load_val and SHALL take priority over incr_en on the same edge.
REQ-023 pc SHALL wrap from 2^ADDR_W-1 to 0 on increment, with no flag.
REQ-024 With ir_en=0, instruction SHALL hold its value; with incr_en=0 and pc_load=0, pc SHALL hold its value.
REQ-025 In any state, prog_mode=1 SHALL move the block to LOAD on the next edge.
REQ-026 In LOAD, prog_we=1 SHALL write prog_data to mem[prog_addr]; ir_en, incr_en and pc_load SHALL be ignored.
REQ-027 In RUN and HALT, prog_we SHALL be ignored.
REQ-028 On prog_mode falling in LOAD, the next edge SHALL enter RUN with pc=0 and instruction=0.
REQ-029 In HALT, ir_en, incr_en and pc_load SHALL be ignored, and pc and instruction SHALL hold.
REQ-030 restart=1 in HALT SHALL enter RUN with pc=0 and instruction=0; restart SHALL be ignored in other states.
REQ-031 If prog_mode and restart are both 1 in HALT, prog_mode SHALL win.
REQ-032 halted and loading SHALL be registered decodes of the state, never high together.

Reset
REQ-033 rst_n low SHALL immediately force state=RUN, pc=0, instruction=0, halted=0 and loading=0.
REQ-034 Program memory contents SHALL NOT be cleared by reset.
REQ-035 Reset asserted mid-write SHALL abort the write, leaving the addressed word either old or new but no other word altered.

Configuration
REQ-036 Macro IFU_HALT_DETECT_EN SHALL control halt detection.
REQ-037 With IFU_HALT_DETECT_EN defined, a RUN capture of an instruction whose opcode is 6'd16 SHALL enter HALT on that same edge, with the instruction visible.
REQ-038 Without IFU_HALT_DETECT_EN, HALT SHALL be unreachable, halted SHALL be tied 0, and opcode 6'd16 SHALL be fetched like any other opcode.

Verification
REQ-039 Load mem[0..2]=16'h0480, 16'h0900, 16'h2801, then drop prog_mode and pulse ir_en+incr_en -> instruction=16'h0480 and pc=1 one cycle later.
REQ-040 pc=8'hFF with incr_en=1 -> pc=8'h00.
REQ-041 pc=5 with pc_load=1, pc_load_val=8'h40 and incr_en=1 on the same edge -> pc=8'h40.
REQ-042 With the macro defined, mem[3]=16'h4000 fetched -> halted=1; then ir_en=1 -> instruction stays 16'h4000; then restart -> pc=0, halted=0.
REQ-043 prog_we=1 in RUN to address 0 with data 16'hFFFF -> mem[0] unchanged on the next fetch.
REQ-044 rst_n low mid-run with pc=7 -> pc=0 and instruction=0 immediately; after release, mem contents are intact on fetch.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: run-time fetch controls, program-load port and status outputs.
// The fetch unit connects through the slave modport; the driving side uses master.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              ir_en;
  logic              incr_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              prog_mode;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              restart;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              loading;

  modport master (
    output ir_en, incr_en, pc_load, pc_load_val,
    output prog_mode, prog_we, prog_addr, prog_data, restart,
    input  instruction, pc, halted, loading
  );

  modport slave (
    input  ir_en, incr_en, pc_load, pc_load_val,
    input  prog_mode, prog_we, prog_addr, prog_data, restart,
    output instruction, pc, halted, loading
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program memory, pc, instruction register and RUN/LOAD/HALT control.
// Define IFU_HALT_DETECT_EN to make a fetched opcode 6'd16 stop the unit in HALT.
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.slave    ifu
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              loading_q;
  logic              mem_we;
  logic [DATA_W-1:0] fetch_word;

  // Program memory is deliberately left out of reset so a reload is not needed after rst_n.
  logic [DATA_W-1:0] mem [DEPTH];

  assign fetch_word = mem[pc_q];

`ifdef IFU_HALT_DETECT_EN
  localparam logic [5:0] HALT_OPC = 6'd16;
  logic halted_q;
  logic halt_hit;

  assign halt_hit = ifu.ir_en && (fetch_word[DATA_W-1 -: 6] == HALT_OPC);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      ir_q      <= '0;
      loading_q <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      loading_q <= (state_d == ST_LOAD);
`ifdef IFU_HALT_DETECT_EN
      halted_q  <= (state_d == ST_HALT);
`endif
    end
  end

  // prog_mode overrides every other transition, including a restart out of HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ifu.ir_en) begin
          ir_d = fetch_word;
        end
        if (ifu.pc_load) begin
          pc_d = ifu.pc_load_val;
        end else if (ifu.incr_en) begin
          pc_d = pc_q + ADDR_W'(1);
        end
`ifdef IFU_HALT_DETECT_EN
        if (halt_hit) begin
          state_d = ST_HALT;
        end
`endif
      end
      ST_LOAD: begin
        mem_we = ifu.prog_we;
        if (!ifu.prog_mode) begin
          state_d = ST_RUN;
          pc_d    = '0;
          ir_d    = '0;
        end
      end
      ST_HALT: begin
        if (ifu.restart && !ifu.prog_mode) begin
          state_d = ST_RUN;
          pc_d    = '0;
          ir_d    = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        pc_d    = '0;
        ir_d    = '0;
      end
    endcase
    if (ifu.prog_mode) begin
      state_d = ST_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ifu.prog_addr] <= ifu.prog_data;
    end
  end

  assign ifu.instruction = ir_q;
  assign ifu.pc          = pc_q;
  assign ifu.loading     = loading_q;
`ifdef IFU_HALT_DETECT_EN
  assign ifu.halted      = halted_q;
`else
  assign ifu.halted      = 1'b0;
`endif

endmodule
